// File: rtl/vector_inst_fetch_decode.sv
// Vector front end: fetches a programmed run of OP-V words, decodes them and
// buffers the decoded bundles in a small FIFO toward the execute stage.
module vector_inst_fetch_decode #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic                  imem_re_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]           imem_data_i,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [5:0]            funct6_o,
  output logic                  vm_o,
  output logic [4:0]            vs2_o,
  output logic [4:0]            vs1_o,
  output logic [4:0]            vd_o,
  output logic [2:0]            funct3_o,
  output logic [1:0]            op_kind_o,
  output logic [63:0]           imm_o,
  output logic                  illegal_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 28;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic                    inflight_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]        occ_q;
  logic [ENT_W-1:0]        fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]        head;
  logic [OCC_W:0]          used;
  logic                    empty, push, pop, issue;

  // Bundle layout: {illegal, kind, funct6, vm, vs2, vs1, vd, funct3}
  function automatic logic [ENT_W-1:0] decode_word(input logic [31:0] w);
    logic [2:0] f3;
    logic [1:0] kind;
    logic       ill;
    f3  = w[14:12];
    ill = (w[6:0] != 7'b1010111) || (f3 == 3'b001) || (f3 == 3'b101) || (f3 == 3'b111);
    case (f3)
      3'b000, 3'b010: kind = 2'b00;
      3'b100, 3'b110: kind = 2'b01;
      3'b011:         kind = 2'b10;
      default:        kind = 2'b11;
    endcase
    if (ill) kind = 2'b11;
    return {ill, kind, w[31:26], w[25], w[24:20], w[19:15], w[11:7], f3};
  endfunction

  function automatic logic signed [63:0] sext_imm(input logic [4:0] v);
    return {{59{v[4]}}, v};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (occ_q == '0);
  assign pop   = !empty && dec_ready_i;
  assign push  = inflight_q;
  // A word in flight lands this cycle, so it already owns a slot; a pop frees one.
  assign used  = (OCC_W+1)'(occ_q) + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
  assign issue = (state_q == FETCH) && (rem_q != '0) && (used < (OCC_W+1)'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = count_i;
          state_d = (count_i == '0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
        end
        if ((rem_q == '0) && !inflight_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q      <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Buffer storage carries no reset; emptiness masks stale contents.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= decode_word(imem_data_i);
  end

  assign head        = empty ? '0 : fifo_q[rd_ptr_q];
  assign {illegal_o, op_kind_o, funct6_o, vm_o, vs2_o, vs1_o, vd_o, funct3_o} = head;
  assign imm_o       = (op_kind_o == 2'b10) ? sext_imm(vs1_o) : '0;
  assign dec_valid_o = !empty;
  assign imem_re_o   = issue;
  assign imem_addr_o = addr_q;
  assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_vector_inst_fetch_decode.sv
// Bench for vector_inst_fetch_decode: memory model, directed runs and random
// runs scored against a queue of expected words decoded from the ISA rules.
module tb_vector_inst_fetch_decode;
  logic        clk = 1'b0;
  logic        rst, start_i, imem_re_o, dec_valid_o, dec_ready_i;
  logic [7:0]  base_addr_i, imem_addr_o;
  logic [8:0]  count_i;
  logic [31:0] imem_data_i;
  logic [5:0]  funct6_o;
  logic        vm_o, illegal_o, busy_o, done_o;
  logic [4:0]  vs2_o, vs1_o, vd_o;
  logic [2:0]  funct3_o;
  logic [1:0]  op_kind_o;
  logic [63:0] imm_o;

  logic [31:0] mem [256];
  int checks = 0, passes = 0, fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data_i <= imem_re_o ? mem[imem_addr_o] : 32'hDEAD_BEEF;

  vector_inst_fetch_decode #(.ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .imem_re_o(imem_re_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .funct6_o(funct6_o), .vm_o(vm_o), .vs2_o(vs2_o), .vs1_o(vs1_o), .vd_o(vd_o),
    .funct3_o(funct3_o), .op_kind_o(op_kind_o), .imm_o(imm_o),
    .illegal_o(illegal_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [2:0] f3,
                                      input logic [4:0] vd, input logic [6:0] op);
    return {f6, vm, vs2, vs1, f3, vd, op};
  endfunction

  // OPIVV/OPMVV -> 0, OPIVX/OPMVX -> 1, OPIVI -> 2, anything else -> 3
  function automatic int ref_kind(input logic [31:0] w);
    if (w[6:0] != 7'h57) return 3;
    case (int'(w[14:12]))
      0, 2:    return 0;
      4, 6:    return 1;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk_entry(input logic [31:0] w);
    int k;
    longint imm;
    k   = ref_kind(w);
    imm = (k == 2) ? longint'($signed(w[19:15])) : 64'd0;
    chk("funct6", 64'(funct6_o), 64'(w[31:26]));
    chk("vm", 64'(vm_o), 64'(w[25]));
    chk("vs2", 64'(vs2_o), 64'(w[24:20]));
    chk("vs1", 64'(vs1_o), 64'(w[19:15]));
    chk("vd", 64'(vd_o), 64'(w[11:7]));
    chk("funct3", 64'(funct3_o), 64'(w[14:12]));
    chk("op_kind", 64'(op_kind_o), 64'(k));
    chk("illegal", 64'(illegal_o), (k == 3) ? 64'd1 : 64'd0);
    chk("imm", imm_o, 64'(imm));
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for `hold` cycles.
  // Cycle 0 is the cycle in which start_i is sampled.
  task automatic run_prog(input int base, input int cnt, input int mode, input int hold,
                          input bit restart, output int done_cyc, output int first_v,
                          output int rd_hold);
    logic [31:0] expq[$];
    logic [63:0] snap;
    bit stall_prev, done_seen;
    int cyc, reads;
    for (int i = 0; i < cnt; i++) expq.push_back(mem[(base + i) % 256]);
    start_i     = 1'b1;
    base_addr_i = 8'(base);
    count_i     = 9'(cnt);
    dec_ready_i = (mode == 2) ? (hold == 0) : 1'b1;
    cyc = 0; reads = 0; done_seen = 0; stall_prev = 0;
    done_cyc = -1; first_v = -1; rd_hold = -1; snap = '0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      if (imem_re_o) begin
        chk("rd_addr", 64'(imem_addr_o), 64'((base + reads) % 256));
        reads++;
      end
      if (stall_prev)
        chk("stable", 64'({funct6_o, vm_o, vs2_o, vs1_o, vd_o, funct3_o, op_kind_o, illegal_o}), snap);
      if (dec_valid_o && first_v < 0) first_v = cyc;
      if (dec_valid_o && dec_ready_i) begin
        if (expq.size() == 0) chk("extra_entry", 64'd1, 64'd0);
        else chk_entry(expq.pop_front());
      end
      stall_prev = dec_valid_o && !dec_ready_i;
      snap = 64'({funct6_o, vm_o, vs2_o, vs1_o, vd_o, funct3_o, op_kind_o, illegal_o});
      if (done_o) begin done_seen = 1; done_cyc = cyc; end
      if (mode == 2 && cyc == hold - 1) rd_hold = reads;
      @(posedge clk); #1;
      start_i = restart && (cyc == 3);
      base_addr_i = 8'(base + 100);
      count_i = 9'd3;
      case (mode)
        0:       dec_ready_i = 1'b1;
        1:       dec_ready_i = ($urandom_range(0, 2) != 0);
        default: dec_ready_i = (cyc + 1 >= hold);
      endcase
      cyc++;
    end
    start_i = 1'b0;
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("all_delivered", 64'(expq.size()), 64'd0);
    chk("read_count", 64'(reads), 64'(cnt));
    @(negedge clk);
    chk("idle_after_done", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d, f, h;
    logic [31:0] w;
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; count_i = '0; dec_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_re", 64'(imem_re_o), 64'd0);
    chk("rst_addr", 64'(imem_addr_o), 64'd0);
    chk("rst_valid", 64'(dec_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_kind", 64'(op_kind_o), 64'd0);
    chk("rst_fields", 64'({funct6_o, vm_o, vs2_o, vs1_o, vd_o, funct3_o, illegal_o}), 64'd0);
    chk("rst_imm", imm_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // vadd.vv v7, v3, v5 at address 0
    mem[0] = enc(6'b000000, 1'b1, 5'd3, 5'd5, 3'b000, 5'd7, 7'b1010111);
    run_prog(0, 1, 0, 0, 0, d, f, h);
    chk("vadd_first_valid", 64'(f), 64'd3);
    chk("vadd_done", 64'(d), 64'd4);

    // OPIVV, OPIVI (vs1 = -2), OPIVX back to back
    mem[8'h20] = enc(6'b000000, 1'b1, 5'd1, 5'd2, 3'b000, 5'd3, 7'h57);
    mem[8'h21] = enc(6'b000000, 1'b0, 5'd4, 5'b11110, 3'b011, 5'd6, 7'h57);
    mem[8'h22] = enc(6'b000010, 1'b1, 5'd7, 5'd8, 3'b100, 5'd9, 7'h57);
    run_prog(8'h20, 3, 0, 0, 0, d, f, h);
    chk("three_first_valid", 64'(f), 64'd3);
    chk("three_done", 64'(d), 64'd6);

    // Ten words with execute stalled for 20 cycles
    for (int i = 0; i < 10; i++)
      mem[8'h30 + i] = enc(6'(i), 1'b1, 5'(i), 5'(i + 1), 3'b010, 5'(i + 2), 7'h57);
    run_prog(8'h30, 10, 2, 20, 0, d, f, h);
    chk("stall_reads", 64'(h), 64'd4);

    // Illegal opcode, illegal funct3, then a legal word
    mem[8'h10] = enc(6'b000000, 1'b1, 5'd1, 5'd1, 3'b000, 5'd1, 7'b0000000);
    mem[8'h11] = enc(6'b000000, 1'b1, 5'd2, 5'd2, 3'b111, 5'd2, 7'h57);
    mem[8'h12] = enc(6'b000000, 1'b1, 5'd3, 5'd5, 3'b000, 5'd7, 7'h57);
    run_prog(8'h10, 3, 0, 0, 0, d, f, h);
    chk("illegal_done", 64'(d), 64'd6);

    // Address wrap
    mem[8'hFF] = enc(6'b000001, 1'b1, 5'd9, 5'd10, 3'b110, 5'd11, 7'h57);
    mem[8'h00] = enc(6'b000000, 1'b1, 5'd3, 5'd5, 3'b000, 5'd7, 7'h57);
    run_prog(8'hFF, 2, 0, 0, 0, d, f, h);
    chk("wrap_done", 64'(d), 64'd5);

    // Reset in FETCH with two entries buffered
    for (int i = 0; i < 6; i++) mem[8'h40 + i] = enc(6'(i), 1'b1, 5'd1, 5'd2, 3'b000, 5'd3, 7'h57);
    start_i = 1'b1; base_addr_i = 8'h40; count_i = 9'd6; dec_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(dec_valid_o), 64'd1);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(dec_valid_o), 64'd0);
    chk("midrst_re", 64'(imem_re_o), 64'd0);
    chk("midrst_addr", 64'(imem_addr_o), 64'd0);
    @(posedge clk); #1;
    dec_ready_i = 1'b1;
    run_prog(8'h40, 6, 0, 0, 0, d, f, h);
    chk("post_rst_done", 64'(d), 64'd9);

    // start_i during a run is ignored
    for (int i = 0; i < 6; i++) mem[8'h50 + i] = enc(6'(i + 3), 1'b0, 5'd6, 5'(i), 3'b011, 5'd4, 7'h57);
    run_prog(8'h50, 6, 1, 0, 1, d, f, h);

    // Zero-length run
    run_prog(8'h70, 0, 0, 0, 0, d, f, h);
    chk("count0_done", 64'(d), 64'd1);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      int b, c;
      b = $urandom_range(0, 255);
      c = $urandom_range(1, 12);
      for (int i = 0; i < c; i++) begin
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = 7'h57;
        mem[(b + i) % 256] = w;
      end
      run_prog(b, c, 1, 0, 0, d, f, h);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
